// File: rtl/trdb_packet_reassembler.sv
// trdb_packet_reassembler: rebuilds length-headed trace packets from a valid/ready stream of words
module trdb_packet_reassembler #(
  parameter int WORD_LEN   = 32,
  parameter int PACKET_LEN = 128,
  parameter int LEN_BITS   = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  input  logic [WORD_LEN-1:0]   word_i,
  output logic                  packet_valid_o,
  input  logic                  packet_ready_i,
  output logic [PACKET_LEN-1:0] packet_bits_o,
  output logic [LEN_BITS-1:0]   packet_len_o
);
  localparam int NW = PACKET_LEN / WORD_LEN;
  localparam int CW = NW > 1 ? $clog2(NW) : 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] OUTPUT  = 2'd2;
  logic [1:0]            state;
  logic [CW-1:0]         cnt, last_q;
  logic [LEN_BITS-1:0]   len_q, hdr, mask_len;
  logic [LEN_BITS:0]     n_words;
  logic [PACKET_LEN-1:0] buf_q, lmask;
  logic [WORD_LEN-1:0]   wmask;
  logic                  word_hs;
  always_comb begin
    hdr      = word_i[LEN_BITS-1:0];
    n_words  = ({1'b0, hdr} + (LEN_BITS+1)'(WORD_LEN - 1)) / (LEN_BITS+1)'(WORD_LEN);
    mask_len = state == IDLE ? hdr : len_q;
    lmask    = ~({PACKET_LEN{1'b1}} << mask_len);
    // each word is masked on entry so bits at or above the length never reach the buffer
    wmask    = word_i & lmask[cnt*WORD_LEN +: WORD_LEN];
    word_ready_o = state != OUTPUT && !clear_i;
    word_hs  = word_valid_i && word_ready_o;
  end
  assign packet_valid_o = state == OUTPUT;
  assign packet_bits_o  = buf_q;
  assign packet_len_o   = len_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      last_q <= '0;
      len_q  <= '0;
      buf_q  <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == OUTPUT) begin
      if (packet_ready_i) state <= IDLE;
    end else if (word_hs) begin
      if (state == IDLE) begin
        if (hdr != '0) begin
          buf_q  <= PACKET_LEN'(wmask);
          len_q  <= hdr;
          last_q <= CW'(n_words - 1);
          state  <= n_words == 1 ? OUTPUT : COLLECT;
          cnt    <= n_words == 1 ? '0 : CW'(1);
        end
      end else begin
        buf_q[cnt*WORD_LEN +: WORD_LEN] <= wmask;
        cnt   <= cnt == last_q ? '0 : cnt + 1'b1;
        state <= cnt == last_q ? OUTPUT : COLLECT;
      end
    end
  end
  a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    packet_valid_o && !packet_ready_i && !clear_i |=> $stable(packet_bits_o) && $stable(packet_len_o));
  a_no_ready_in_output: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(state == OUTPUT && word_ready_o));
endmodule

// File: tb/tb_trdb_packet_reassembler.sv
// tb_trdb_packet_reassembler: directed scenarios plus a random stream checked against a packet-level model
module tb_trdb_packet_reassembler;
  logic         clk_i = 0, rst_ni = 0, clear_i = 0;
  logic         word_valid_i = 0, word_ready_o, packet_valid_o, packet_ready_i = 0;
  logic [31:0]  word_i = '0;
  logic [127:0] packet_bits_o;
  logic [6:0]   packet_len_o;
  int total = 0, bad = 0;

  trdb_packet_reassembler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_i(word_i),
    .packet_valid_o(packet_valid_o), .packet_ready_i(packet_ready_i),
    .packet_bits_o(packet_bits_o), .packet_len_o(packet_len_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic put_word(input logic [31:0] w);
    int n = 0;
    @(negedge clk_i);
    word_valid_i = 1;
    word_i = w;
    while (!word_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (n == 100) begin
      bad++;
      $display("FAIL put_word timeout: word_ready stayed %0b, required 1", word_ready_o);
    end
    @(posedge clk_i);
    #1 word_valid_i = 0;
  endtask

  task automatic pop();
    @(negedge clk_i);
    packet_ready_i = 1;
    @(posedge clk_i);
    #1 packet_ready_i = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    total += 4;
    if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", packet_valid_o); end
    if (packet_bits_o !== '0) begin bad++; $display("FAIL reset bits: got %h want 0", packet_bits_o); end
    if (packet_len_o !== '0) begin bad++; $display("FAIL reset len: got %0d want 0", packet_len_o); end
    if (word_ready_o !== 1'b1) begin bad++; $display("FAIL reset word_ready: got %b want 1", word_ready_o); end
    rst_ni = 1;
  endtask

  task automatic test_single();
    put_word(32'h0000_A514);
    @(negedge clk_i);
    total += 4;
    if (packet_valid_o !== 1'b1) begin bad++; $display("FAIL single valid: got %b want 1", packet_valid_o); end
    if (packet_len_o !== 7'd20) begin bad++; $display("FAIL single len: got %0d want 20", packet_len_o); end
    if (packet_bits_o !== 128'h0A514) begin bad++; $display("FAIL single bits: got %h want 0a514", packet_bits_o); end
    if (word_ready_o !== 1'b0) begin bad++; $display("FAIL single word_ready: got %b want 0", word_ready_o); end
    pop();
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL single drop valid: got %b want 0", packet_valid_o); end
  endtask

  task automatic test_len100_hold();
    logic [127:0] exp;
    logic [127:0] b0;
    logic [6:0]   l0;
    exp = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFE4} & ((128'd1 << 100) - 1);
    put_word(32'hFFFF_FFE4);
    repeat (2) put_word(32'hFFFF_FFFF);
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL len100 early valid: got %b want 0", packet_valid_o); end
    put_word(32'hFFFF_FFFF);
    @(negedge clk_i);
    total += 3;
    if (packet_valid_o !== 1'b1) begin bad++; $display("FAIL len100 valid: got %b want 1", packet_valid_o); end
    if (packet_len_o !== 7'd100) begin bad++; $display("FAIL len100 len: got %0d want 100", packet_len_o); end
    if (packet_bits_o !== exp) begin bad++; $display("FAIL len100 bits: got %h want %h", packet_bits_o, exp); end
    b0 = packet_bits_o;
    l0 = packet_len_o;
    word_valid_i = 1;
    word_i = 32'h0000_0001;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      total++;
      if (packet_bits_o !== b0 || packet_len_o !== l0 || word_ready_o !== 1'b0 || packet_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL hold cycle %0d: bits %h len %0d ready %b valid %b, want bits %h len %0d ready 0 valid 1",
                 c, packet_bits_o, packet_len_o, word_ready_o, packet_valid_o, b0, l0);
      end
    end
    packet_ready_i = 1;
    @(posedge clk_i);
    #1 packet_ready_i = 0;
    @(negedge clk_i);
    total += 2;
    if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL hold release valid: got %b want 0", packet_valid_o); end
    if (word_ready_o !== 1'b1) begin bad++; $display("FAIL hold release word_ready: got %b want 1", word_ready_o); end
    @(posedge clk_i);
    #1 word_valid_i = 0;
    @(negedge clk_i);
    total += 2;
    if (packet_valid_o !== 1'b1) begin bad++; $display("FAIL held word valid: got %b want 1", packet_valid_o); end
    if (packet_len_o !== 7'd1 || packet_bits_o !== 128'd1) begin
      bad++;
      $display("FAIL held word packet: len %0d bits %h, want len 1 bits 1", packet_len_o, packet_bits_o);
    end
    pop();
  endtask

  task automatic test_filler();
    for (int k = 0; k < 2; k++) begin
      put_word(32'h0);
      @(negedge clk_i);
      total++;
      if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL filler %0d valid: got %b want 0", k, packet_valid_o); end
    end
    put_word(32'h0000_0508);
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b1 || packet_len_o !== 7'd8 || packet_bits_o !== 128'h08) begin
      bad++;
      $display("FAIL filler packet: valid %b len %0d bits %h, want valid 1 len 8 bits 08", packet_valid_o, packet_len_o, packet_bits_o);
    end
    pop();
  endtask

  task automatic test_clear();
    put_word(32'hABCD_0046);
    put_word(32'h1111_1111);
    @(negedge clk_i);
    clear_i = 1;
    word_valid_i = 1;
    word_i = 32'h2222_2222;
    #1;
    total++;
    if (word_ready_o !== 1'b0) begin bad++; $display("FAIL clear word_ready: got %b want 0", word_ready_o); end
    @(posedge clk_i);
    #1 begin clear_i = 0; word_valid_i = 0; end
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b0) begin bad++; $display("FAIL clear valid: got %b want 0", packet_valid_o); end
    put_word(32'h0000_0010);
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b1 || packet_len_o !== 7'd16 || packet_bits_o !== 128'h10) begin
      bad++;
      $display("FAIL after clear packet: valid %b len %0d bits %h, want valid 1 len 16 bits 10", packet_valid_o, packet_len_o, packet_bits_o);
    end
    pop();
  endtask

  task automatic test_reset_output();
    put_word(32'h0000_0005);
    @(negedge clk_i);
    total++;
    if (packet_valid_o !== 1'b1) begin bad++; $display("FAIL pre-reset valid: got %b want 1", packet_valid_o); end
    rst_ni = 0;
    #1;
    total++;
    if (packet_valid_o !== 1'b0 || packet_bits_o !== '0 || packet_len_o !== '0) begin
      bad++;
      $display("FAIL async reset: valid %b len %0d bits %h, want all 0", packet_valid_o, packet_len_o, packet_bits_o);
    end
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_random();
    logic [31:0]  words[$];
    logic [127:0] eb[$];
    logic [6:0]   el[$];
    logic [127:0] pkt;
    int idx = 0, got = 0, cyc = 0, i = 0;
    for (int p = 0; p < 40; p++) begin
      int l, n;
      if ($urandom_range(0, 9) == 0) words.push_back(32'h0 | ($urandom & 32'hFFFF_FF80));
      l = $urandom_range(1, 127);
      n = (l + 31) / 32;
      words.push_back(($urandom & 32'hFFFF_FF80) | l);
      for (int k = 1; k < n; k++) words.push_back($urandom);
    end
    while (i < words.size()) begin
      int l, n;
      l = words[i] % 128;
      if (l == 0) begin i++; continue; end
      n = (l + 31) / 32;
      pkt = '0;
      for (int k = 0; k < n; k++) pkt[k*32 +: 32] = words[i+k];
      pkt &= (128'd1 << l) - 1;
      eb.push_back(pkt);
      el.push_back(7'(l));
      i += n;
    end
    while ((idx < words.size() || got < eb.size()) && cyc < 20000) begin
      @(negedge clk_i);
      cyc++;
      word_valid_i = idx < words.size() && $urandom_range(0, 3) != 0;
      word_i = idx < words.size() ? words[idx] : 32'h0;
      packet_ready_i = $urandom_range(0, 2) != 0;
      #1;
      if (packet_valid_o && packet_ready_i) begin
        total++;
        if (got >= eb.size()) begin
          bad++;
          $display("FAIL random extra packet: len %0d bits %h, want none", packet_len_o, packet_bits_o);
        end else if (packet_bits_o !== eb[got] || packet_len_o !== el[got]) begin
          bad++;
          $display("FAIL random packet %0d: len %0d bits %h, want len %0d bits %h", got, packet_len_o, packet_bits_o, el[got], eb[got]);
        end
        got++;
      end
      if (word_valid_i && word_ready_o) idx++;
    end
    word_valid_i = 0;
    packet_ready_i = 0;
    total++;
    if (got != eb.size() || idx != words.size()) begin
      bad++;
      $display("FAIL random completion: packets %0d words %0d, want packets %0d words %0d", got, idx, eb.size(), words.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_len100_hold();
    test_filler();
    test_clear();
    test_reset_output();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
